// File: rtl/seven_segment_scanner.sv
// Multiplexed hex seven-segment driver. Loads are double-buffered and take effect
// only at frame boundaries, so a digit never changes partway through a frame.
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzs,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_pulse,
  output logic                    pending
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] scanCount;
  logic [IW-1:0] digitIdx;
  logic          tick;
  logic          frameEdge;

  logic [4*NUM_DIGITS-1:0] shadowData, activeData;
  logic [NUM_DIGITS-1:0]   shadowDp, activeDp;
  logic [NUM_DIGITS-1:0]   shadowBlank, activeBlank;

  logic [3:0]            curNibble;
  logic                  curDp;
  logic                  curBlank;
  logic                  zeroRun;
  logic [6:0]            segRaw;
  logic [NUM_DIGITS-1:0] digitOneHot;

  assign tick      = (scanCount == CNT_LAST);
  assign frameEdge = tick && (digitIdx == IDX_LAST);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      scanCount <= '0;
      digitIdx  <= '0;
    end else if (tick) begin
      scanCount <= '0;
      digitIdx  <= (digitIdx == IDX_LAST) ? '0 : digitIdx + IW'(1);
    end else begin
      scanCount <= scanCount + CW'(1);
    end
  end

  // A load landing on the boundary bypasses the shadow so pending never rises.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      shadowData  <= '0;
      shadowDp    <= '0;
      shadowBlank <= '0;
      activeData  <= '0;
      activeDp    <= '0;
      activeBlank <= '0;
      pending     <= 1'b0;
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= 1'b0;
      if (load) begin
        shadowData  <= data_in;
        shadowDp    <= dp_in;
        shadowBlank <= blank_in;
      end
      if (frameEdge) begin
        pending <= 1'b0;
        if (load) begin
          activeData  <= data_in;
          activeDp    <= dp_in;
          activeBlank <= blank_in;
          frame_pulse <= 1'b1;
        end else if (pending) begin
          activeData  <= shadowData;
          activeDp    <= shadowDp;
          activeBlank <= shadowBlank;
          frame_pulse <= 1'b1;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Walk from the most significant digit down so zeroRun tracks "this and all above are zero".
  always_comb begin
    curNibble   = '0;
    curDp       = 1'b0;
    curBlank    = 1'b0;
    zeroRun     = 1'b1;
    digitOneHot = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeroRun = zeroRun && (activeData[4*i +: 4] == 4'h0);
      if (digitIdx == IW'(i)) begin
        digitOneHot[i] = 1'b1;
        curNibble      = activeData[4*i +: 4];
        curDp          = activeDp[i];
        curBlank       = activeBlank[i] || (lzs && (i != 0) && zeroRun);
      end
    end
  end

  always_comb begin
    segRaw = 7'h00;
    case (curNibble)
      4'h0: segRaw = 7'h3F;
      4'h1: segRaw = 7'h06;
      4'h2: segRaw = 7'h5B;
      4'h3: segRaw = 7'h4F;
      4'h4: segRaw = 7'h66;
      4'h5: segRaw = 7'h6D;
      4'h6: segRaw = 7'h7D;
      4'h7: segRaw = 7'h07;
      4'h8: segRaw = 7'h7F;
      4'h9: segRaw = 7'h6F;
      4'hA: segRaw = 7'h77;
      4'hB: segRaw = 7'h7C;
      4'hC: segRaw = 7'h39;
      4'hD: segRaw = 7'h5E;
      4'hE: segRaw = 7'h79;
      4'hF: segRaw = 7'h71;
      default: segRaw = 7'h00;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      seg      <= {7{ACTIVE_LOW}};
      dp       <= ACTIVE_LOW;
      digit_en <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      seg      <= (curBlank ? 7'h00 : segRaw) ^ {7{ACTIVE_LOW}};
      dp       <= (curDp && !curBlank) ^ ACTIVE_LOW;
      digit_en <= digitOneHot ^ {NUM_DIGITS{ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Drives an active-high and an active-low scanner with the same stimulus and
// compares both against a cycle-count based model of the display behaviour.
module tb_seven_segment_scanner;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lzs;
  logic        load;

  logic [6:0] segHigh, segLow;
  logic       dpHigh, dpLow;
  logic [3:0] enHigh, enLow;
  logic       fpHigh, fpLow;
  logic       pendHigh, pendLow;

  int checks = 0;
  int passes = 0;

  int          n;
  logic [15:0] mActData, mShData;
  logic [3:0]  mActDp, mActBl, mShDp, mShBl;
  logic        mPend;
  logic [6:0]  segTable [16];

  always #5 clk = ~clk;

  seven_segment_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(1'b0)) dutHigh (
    .clk(clk), .clr(clr), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .lzs(lzs), .load(load), .seg(segHigh), .dp(dpHigh), .digit_en(enHigh),
    .frame_pulse(fpHigh), .pending(pendHigh)
  );

  seven_segment_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dutLow (
    .clk(clk), .clr(clr), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .lzs(lzs), .load(load), .seg(segLow), .dp(dpLow), .digit_en(enLow),
    .frame_pulse(fpLow), .pending(pendLow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
  endtask

  task automatic modelReset();
    n        = 0;
    mActData = '0;
    mActDp   = '0;
    mActBl   = '0;
    mShData  = '0;
    mShDp    = '0;
    mShBl    = '0;
    mPend    = 1'b0;
  endtask

  // Called just after a checked edge; pulls clr mid-cycle to exercise the async path.
  task automatic resetCheck();
    #2;
    load = 1'b0;
    clr  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checkOutput("rst_seg_hi", {25'b0, segHigh}, 32'h00);
      checkOutput("rst_seg_lo", {25'b0, segLow}, 32'h7F);
      checkOutput("rst_dp_hi", {31'b0, dpHigh}, 32'h0);
      checkOutput("rst_dp_lo", {31'b0, dpLow}, 32'h1);
      checkOutput("rst_en_hi", {28'b0, enHigh}, 32'h0);
      checkOutput("rst_en_lo", {28'b0, enLow}, 32'hF);
      checkOutput("rst_pend", {30'b0, pendHigh, pendLow}, 32'h0);
      checkOutput("rst_fp", {30'b0, fpHigh, fpLow}, 32'h0);
      if (k == 0) @(posedge clk);
    end
    #2;
    clr = 1'b0;
    modelReset();
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] d, input logic [3:0] dpv,
                               input logic [3:0] bl, input logic lz);
    int         idx;
    logic       boundary, blanked;
    logic [3:0] nib;
    logic [6:0] expSeg;
    logic       expDp, expFp;
    logic [3:0] expEn;

    @(negedge clk);
    load     = ld;
    data_in  = d;
    dp_in    = dpv;
    blank_in = bl;
    lzs      = lz;
    @(posedge clk);

    idx      = (n / SD) % ND;
    boundary = (n % FRAME) == FRAME - 1;
    nib      = 4'((mActData >> (4 * idx)) & 16'hF);
    blanked  = mActBl[idx] || (lz && idx != 0 && (mActData >> (4 * idx)) == 16'h0);
    expSeg   = blanked ? 7'h00 : segTable[nib];
    expDp    = mActDp[idx] && !blanked;
    expEn    = 4'(1 << idx);
    expFp    = boundary && (ld || mPend);

    if (boundary) begin
      if (ld) begin
        mActData = d;
        mActDp   = dpv;
        mActBl   = bl;
      end else if (mPend) begin
        mActData = mShData;
        mActDp   = mShDp;
        mActBl   = mShBl;
      end
      mPend = 1'b0;
    end else if (ld) begin
      mPend = 1'b1;
    end
    if (ld) begin
      mShData = d;
      mShDp   = dpv;
      mShBl   = bl;
    end
    n++;

    #1;
    checkOutput("seg_hi", {25'b0, segHigh}, {25'b0, expSeg});
    checkOutput("seg_lo", {25'b0, segLow}, {25'b0, ~expSeg});
    checkOutput("dp_hi", {31'b0, dpHigh}, {31'b0, expDp});
    checkOutput("dp_lo", {31'b0, dpLow}, {31'b0, ~expDp});
    checkOutput("en_hi", {28'b0, enHigh}, {28'b0, expEn});
    checkOutput("en_lo", {28'b0, enLow}, {28'b0, ~expEn});
    checkOutput("fp", {30'b0, fpHigh, fpLow}, {30'b0, expFp, expFp});
    checkOutput("pending", {30'b0, pendHigh, pendLow}, {30'b0, mPend, mPend});
  endtask

  task automatic idle(input int cycles, input logic lz);
    for (int k = 0; k < cycles; k++) applyStimulus(1'b0, 16'h0, 4'h0, 4'h0, lz);
  endtask

  task automatic waitSlot(input int slot, input logic lz);
    for (int k = 0; k < FRAME && (n % FRAME) != slot; k++) idle(1, lz);
  endtask

  initial begin
    segTable = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    clr      = 1'b1;
    load     = 1'b0;
    data_in  = '0;
    dp_in    = '0;
    blank_in = '0;
    lzs      = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    resetCheck();

    $display("[TB] basic load 12AF");
    idle(3, 1'b0);
    applyStimulus(1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0);
    idle(36, 1'b0);

    $display("[TB] leading-zero suppression");
    applyStimulus(1'b1, 16'h0005, 4'h0, 4'h0, 1'b1);
    idle(36, 1'b1);
    idle(20, 1'b0);

    $display("[TB] double load in one frame");
    waitSlot(0, 1'b0);
    applyStimulus(1'b1, 16'hAAAA, 4'h3, 4'h0, 1'b0);
    idle(3, 1'b0);
    applyStimulus(1'b1, 16'hB0B0, 4'h0, 4'h0, 1'b0);
    idle(36, 1'b0);

    $display("[TB] load on frame boundary");
    waitSlot(FRAME - 1, 1'b0);
    applyStimulus(1'b1, 16'h3C7E, 4'h0, 4'h0, 1'b0);
    idle(20, 1'b0);

    $display("[TB] clear with pending data");
    waitSlot(2, 1'b0);
    applyStimulus(1'b1, 16'h9999, 4'hF, 4'h0, 1'b0);
    idle(3, 1'b0);
    resetCheck();
    idle(20, 1'b0);

    $display("[TB] decimal point and blank polarity");
    applyStimulus(1'b1, 16'h8888, 4'b0100, 4'b1000, 1'b0);
    idle(36, 1'b0);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        resetCheck();
      end else begin
        applyStimulus($urandom_range(0, 9) == 0, 16'($urandom),
                      4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                      1'($urandom));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 4, giving the number of display digits (range 1..8).
REQ-002 The module SHALL have parameter SCAN_DIV, default 50000, giving the clock cycles each digit is shown (range 2..2^20).
REQ-003 The module SHALL have parameter ACTIVE_LOW, default 1; 1 drives a lit segment or enabled digit as 0, and 0 drives it as 1.
REQ-004 The module SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port clr, input, width 1: reset, asynchronous and active-high.
REQ-006 The module SHALL have port data_in, input, width 4*NUM_DIGITS: hex nibbles; nibble 0 is the rightmost digit.
REQ-007 The module SHALL have port dp_in, input, width NUM_DIGITS: decimal-point request per digit.
REQ-008 The module SHALL have port blank_in, input, width NUM_DIGITS: force-blank per digit.
REQ-009 The module SHALL have port lzs, input, width 1: leading-zero suppression enable, sampled live.
REQ-010 The module SHALL have port load, input, width 1: single-cycle strobe that captures data_in, dp_in and blank_in.
REQ-011 The module SHALL have port seg, output, width 7: segments in the order {g,f,e,d,c,b,a}, registered.
REQ-012 The module SHALL have port dp, output, width 1: decimal point, registered.
REQ-013 The module SHALL have port digit_en, output, width NUM_DIGITS: one-hot digit select, registered.
REQ-014 The module SHALL have port frame_pulse, output, width 1: high for one cycle when a frame commit occurs.
REQ-015 The module SHALL have port pending, output, width 1: high while loaded data awaits commit.

Function
REQ-016 The prescaler SHALL count 0..SCAN_DIV-1, wrap to 0, and assert an internal tick in the cycle the count equals SCAN_DIV-1.
REQ-017 On each tick the digit index SHALL advance by one, wrapping from NUM_DIGITS-1 to 0.
REQ-018 A frame boundary SHALL be the tick at which the index equals NUM_DIGITS-1.
REQ-019 On load, the inputs SHALL be captured into a shadow register and pending SHALL be set the next cycle.
REQ-020 At a frame boundary with pending=1, the shadow register SHALL be copied to the active register, pending SHALL clear, and frame_pulse SHALL assert for exactly one cycle.
REQ-021 A frame boundary with pending=0 SHALL leave the active register unchanged and keep frame_pulse low.
REQ-022 A load coinciding with a frame boundary SHALL commit the newly loaded value directly, assert frame_pulse, and leave pending at 0.
REQ-023 A second load before commit SHALL overwrite the shadow register; only the last value is committed.
REQ-024 Every cycle, seg, dp and digit_en SHALL register the encoding of the active digit at the current index, giving one cycle of latency from the index.
REQ-025 The nibble encoding SHALL be, with a lit segment as 1 before polarity: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-026 A digit SHALL be blanked (seg and dp unlit, digit_en still asserted) if its blank bit is set.
REQ-027 When lzs=1, a digit SHALL also be blanked if it and every more-significant digit are zero, excluding digit 0.
REQ-028 Digit 0 SHALL never be suppressed by lzs.
REQ-029 dp SHALL be lit when the active dp bit is set and the digit is not blanked.
REQ-030 Exactly one digit_en bit SHALL be asserted in every cycle after the first post-reset edge.
REQ-031 When ACTIVE_LOW=1, seg, dp and digit_en SHALL be bitwise inverted relative to the active-high encoding.

Reset
REQ-032 While clr=1, the prescaler, index, active register, shadow register, pending and frame_pulse SHALL be 0.
REQ-033 While clr=1, seg, dp and digit_en SHALL be unlit and disabled in the selected polarity (all-ones when ACTIVE_LOW=1).
REQ-034 clr asserted mid-frame SHALL discard any pending data immediately.
REQ-035 The first rising edge after clr deasserts SHALL drive digit 0 with blank data, showing '0' (3F before polarity).

Verification
REQ-036 With NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=0: load data_in=16'h12AF, dp_in=0, blank_in=0 -> after commit frame_pulse pulses once; digits 0..3 show 71, 77, 5B, 06, each held 4 cycles, with digit_en stepping 0001, 0010, 0100, 1000.
REQ-037 Load 16'h0005 with lzs=1 -> digit 0 shows 6D and digits 1..3 are blank with digit_en still cycling; set lzs=0 -> digits 1..3 show 3F.
REQ-038 Load A then load B within the same frame -> pending stays 1 until the boundary, only B is displayed, and frame_pulse pulses once.
REQ-039 Assert load in the same cycle as the frame-boundary tick -> the new data shows from the next digit-0 slot and pending never asserts.
REQ-040 Assert clr mid-frame with pending=1 -> all outputs are off immediately, pending=0, and digit 0 shows 3F after release.
REQ-041 With ACTIVE_LOW=1, dp_in=4'b0100 and blank_in=4'b1000 -> digit 2 drives dp=0, digit 3 drives seg=7F, and digit_en is the inverted one-hot.
